// File: rtl/trace_sink.sv
// Packet sink: filters frames by destination address, enforces the keep rules and keeps statistics.
// Define TRACE_SINK_BCAST_EN to also accept the broadcast destination address.
module trace_sink #(
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stream_valid,
  output logic              stream_ready,
  input  logic [63:0]       stream_bits_data,
  input  logic [7:0]        stream_bits_keep,
  input  logic              stream_bits_last,
  input  logic [47:0]       macAddr,
  input  logic [31:0]       length,
  input  logic              hold,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  byte_count,
  output logic [DROP_W-1:0] drop_count,
  output logic [15:0]       last_len,
  output logic              proto_err,
  output logic              done
);

  localparam int MAXW = (CNT_W > DROP_W) ? CNT_W : DROP_W;
  localparam int TW   = ((MAXW > 32) ? MAXW : 32) + 1;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;

  state_e              state_q, state_d;
  logic                started_q;
  logic                ready_q;
  logic [15:0]         acc_q, acc_d;
  logic [CNT_W-1:0]    pkt_q, pkt_d;
  logic [CNT_W-1:0]    byte_q, byte_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [15:0]         lastLen_q, lastLen_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                handshake;
  logic [3:0]          beatBytes;
  logic                keepContig;
  logic                beatViol;
  logic                destMatch;
  logic [16:0]         accSum;
  logic [15:0]         accBeat;
  logic [CNT_W:0]      byteSum;
  logic [TW-1:0]       total;
  logic                commitAcc;
  logic                commitDrop;
  logic                unusedData;

  assign handshake  = stream_valid && ready_q;
  assign beatBytes  = 4'($countones(stream_bits_keep));
  // Contiguous from bit 0 means keep+1 is a power of two.
  assign keepContig = (stream_bits_keep != 8'd0) &&
                      ((stream_bits_keep & (stream_bits_keep + 8'd1)) == 8'd0);
  assign beatViol   = stream_bits_last ? !keepContig : (stream_bits_keep != 8'hFF);
  assign unusedData = ^stream_bits_data[63:48];

`ifdef TRACE_SINK_BCAST_EN
  assign destMatch = (stream_bits_data[47:0] == macAddr) ||
                     (stream_bits_data[47:0] == 48'hFFFF_FFFF_FFFF);
`else
  assign destMatch = (stream_bits_data[47:0] == macAddr);
`endif

  assign accSum  = {1'b0, acc_q} + 17'(beatBytes);
  assign accBeat = accSum[16] ? 16'hFFFF : accSum[15:0];
  assign byteSum = {1'b0, byte_q} + (CNT_W+1)'(accBeat);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pkt_d      = pkt_q;
    byte_d     = byte_q;
    drop_d     = drop_q;
    lastLen_d  = lastLen_q;
    err_d      = err_q;
    commitAcc  = 1'b0;
    commitDrop = 1'b0;

    if (handshake) begin
      if (beatViol) err_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (stream_bits_last) begin
            commitAcc  = destMatch && !beatViol;
            commitDrop = !(destMatch && !beatViol);
          end else begin
            state_d = (destMatch && !beatViol) ? BODY : DROP;
          end
        end
        BODY: begin
          if (stream_bits_last) begin
            commitAcc  = !beatViol;
            commitDrop = beatViol;
          end else if (beatViol) begin
            state_d = DROP;
          end
        end
        DROP: begin
          if (stream_bits_last) commitDrop = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (stream_bits_last) begin
        state_d = IDLE;
        acc_d   = 16'd0;
      end else begin
        acc_d = accBeat;
      end
    end

    if (commitAcc) begin
      pkt_d     = (pkt_q == '1) ? pkt_q : pkt_q + CNT_W'(1);
      byte_d    = byteSum[CNT_W] ? '1 : byteSum[CNT_W-1:0];
      lastLen_d = accBeat;
    end
    if (commitDrop) begin
      drop_d = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
    end

    // Use next-state counts so done rises together with the final commit.
    total  = TW'(pkt_d) + TW'(drop_d);
    done_d = done_q || ((length != 32'd0) && (total >= TW'(length)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      ready_q   <= 1'b0;
      acc_q     <= 16'd0;
      pkt_q     <= '0;
      byte_q    <= '0;
      drop_q    <= '0;
      lastLen_q <= 16'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      ready_q   <= started_q && !hold;
      acc_q     <= acc_d;
      pkt_q     <= pkt_d;
      byte_q    <= byte_d;
      drop_q    <= drop_d;
      lastLen_q <= lastLen_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign stream_ready = ready_q;
  assign pkt_count    = pkt_q;
  assign byte_count   = byte_q;
  assign drop_count   = drop_q;
  assign last_len     = lastLen_q;
  assign proto_err    = err_q;
  assign done         = done_q;

endmodule

// File: doc/trace_sink.md
TRACE_SINK -- requirements
Module: trace_sink

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the accepted-packet and accepted-byte counters.
REQ-002 SHALL have parameter DROP_W, default 16: width of the drop counter.
REQ-003 SHALL have port clock, input, 1: sole clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port stream_valid, input, 1: beat offered.
REQ-006 SHALL have port stream_ready, output, 1: beat accepted when high with stream_valid.
REQ-007 SHALL have port stream_bits_data, input, 64: beat data, byte 0 in [7:0].
REQ-008 SHALL have port stream_bits_keep, input, 8: byte-valid mask.
REQ-009 SHALL have port stream_bits_last, input, 1: final beat of packet.
REQ-010 SHALL have port macAddr, input, 48: local station address.
REQ-011 SHALL have port length, input, 32: expected total packet count (accepted + dropped); 0 disables done.
REQ-012 SHALL have port hold, input, 1: backpressure request.
REQ-013 SHALL have port pkt_count, output, CNT_W: accepted packets.
REQ-014 SHALL have port byte_count, output, CNT_W: bytes of accepted packets.
REQ-015 SHALL have port drop_count, output, DROP_W: dropped packets.
REQ-016 SHALL have port last_len, output, 16: byte length of most recent accepted packet.
REQ-017 SHALL have port proto_err, output, 1: sticky keep-rule violation.
REQ-018 SHALL have port done, output, 1: expected packet total reached.

Function
REQ-019 SHALL drive stream_ready as a register equal to !hold from the previous cycle; a handshake is stream_valid && stream_ready.
REQ-020 SHALL implement states IDLE, BODY and DROP; IDLE is entered at reset.
REQ-021 On a handshake in IDLE, dest = data[47:0] SHALL be compared to macAddr; a match goes to BODY, a mismatch to DROP; if last is also set, the packet SHALL commit in that beat and the state stays IDLE.
REQ-022 On a last-beat handshake in BODY or DROP, the block SHALL commit and return to IDLE.
REQ-023 Beat bytes SHALL equal popcount(keep); a per-packet 16-bit accumulator SHALL sum them, saturating at 0xFFFF.
REQ-024 A keep-rule violation SHALL be: a non-last beat with keep != 8'hFF, or a last beat whose keep is zero or not contiguous from bit 0.
REQ-025 A violation SHALL set proto_err and force the packet to commit as dropped, even if its address matched.
REQ-026 Commit-accept SHALL increment pkt_count, add the accumulator to byte_count, and load last_len; all SHALL be visible the cycle after the last beat.
REQ-027 Commit-drop SHALL increment drop_count only.
REQ-028 All counters SHALL saturate at all-ones and never wrap.
REQ-029 done SHALL be registered, high when length != 0 and pkt_count + drop_count >= length, and SHALL stay high.
REQ-030 hold asserting mid-packet SHALL only stall; the FSM and accumulator are preserved.

Reset
REQ-031 Asserting reset SHALL immediately force state IDLE, stream_ready 0, every counter, last_len and the accumulator 0, and proto_err and done 0.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet without counting it.
REQ-033 stream_ready SHALL rise no earlier than the second clock edge after reset deasserts.

Configuration
REQ-034 With TRACE_SINK_BCAST_EN defined, dest 48'hFFFF_FFFF_FFFF SHALL also match; without it, only macAddr matches.

Verification
REQ-035 Send a 3-beat packet to macAddr with keeps FF, FF, 0F -> pkt_count 1, byte_count 20, last_len 20.
REQ-036 Send a 1-beat packet to another address with keep 3F -> drop_count 1, pkt_count 0, state IDLE.
REQ-037 Send a broadcast packet -> accepted with TRACE_SINK_BCAST_EN defined, dropped without it.
REQ-038 Send a matching packet with a middle keep of 7F -> proto_err 1, drop_count +1, pkt_count unchanged.
REQ-039 Set length=2, send 1 accepted and 1 dropped packet with hold toggling every 3 cycles -> done rises the cycle after the second last beat, and no beats are lost.
REQ-040 Assert reset during beat 2 of 4, then resend the full packet -> pkt_count 1, byte_count equals only the resent packet.
